// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared definitions for the IF/DM memory bus arbiter.
// State encodings, bus bundle type and default configuration.
package riscv_mem_arbiter_pkg;

    localparam int         XLEN            = 32;
    localparam int         ARB_TIMEOUT_DEF = 255;
    localparam logic [3:0] IF_BYTE_SEL     = 4'b1111;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_DM = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic            req;
        logic [XLEN-1:0] addr;
        logic            wr_en;
        logic [XLEN-1:0] wr_data;
        logic [3:0]      byte_sel;
    } bus_t;

endpackage

// File: rtl/riscv_arb_watchdog.sv
// Bus-ack watchdog for the memory arbiter (RISCV_ARB_TIMEOUT_EN builds).
// Counts busy cycles without ack; expires on the TIMEOUT_CYCLES-th one.
module riscv_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic busy_i,
    input  logic ack_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear on grant, count each busy cycle the bus leaves unanswered.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (busy_i && !ack_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expire_o = busy_i & ~ack_i & (cnt_q == LAST);

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one memory bus between fetch (IF) and data (DM), data first.
// Optional bus-ack watchdog: define RISCV_ARB_TIMEOUT_EN.
module riscv_mem_arbiter
    import riscv_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEF,
    parameter int CNT_W          = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_if_req,
    input  logic [XLEN-1:0] i_if_addr,
    output logic            o_if_ack,
    output logic [XLEN-1:0] o_if_rd_data,
    input  logic            i_dm_req,
    input  logic            i_dm_wr_en,
    input  logic [XLEN-1:0] i_dm_addr,
    input  logic [XLEN-1:0] i_dm_wr_data,
    input  logic [3:0]      i_dm_byte_sel,
    output logic            o_dm_ack,
    output logic [XLEN-1:0] o_dm_rd_data,
    output logic            o_arb_stall_f,
    output logic            o_arb_stall_m,
    output logic            o_bus_req,
    output logic [XLEN-1:0] o_bus_addr,
    output logic            o_bus_wr_en,
    output logic [XLEN-1:0] o_bus_wr_data,
    output logic [3:0]      o_bus_byte_sel,
    input  logic            i_bus_ack,
    input  logic [XLEN-1:0] i_bus_rd_data
`ifdef RISCV_ARB_TIMEOUT_EN
    ,
    output logic            o_arb_err
`endif
);

    arb_state_e      state_q, state_d;
    bus_t            bus_q, bus_d;
    logic            if_ack_q, if_ack_d;
    logic            dm_ack_q, dm_ack_d;
    logic [XLEN-1:0] if_rd_q, if_rd_d;
    logic [XLEN-1:0] dm_rd_q, dm_rd_d;
    logic            if_elig, dm_elig;
    logic            bus_ack;
    logic            abort;

    // A requester being acked this cycle is still holding its old request.
    assign if_elig = i_if_req & ~if_ack_q;
    assign dm_elig = i_dm_req & ~dm_ack_q;
    assign bus_ack = i_bus_ack & bus_q.req;

`ifdef RISCV_ARB_TIMEOUT_EN
    logic err_q, err_d;
    logic grant;

    assign grant = (state_q == ARB_IDLE) & (dm_elig | if_elig);

    riscv_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_watchdog (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .clear_i (grant),
        .busy_i  (state_q != ARB_IDLE),
        .ack_i   (bus_ack),
        .expire_o(abort)
    );

    assign o_arb_err = err_q;
`else
    assign abort = 1'b0;
`endif

    // Grant selection, bus hold and completion/abort handling.
    always_comb begin
        state_d  = state_q;
        bus_d    = bus_q;
        if_ack_d = 1'b0;
        dm_ack_d = 1'b0;
        if_rd_d  = if_rd_q;
        dm_rd_d  = dm_rd_q;
`ifdef RISCV_ARB_TIMEOUT_EN
        err_d    = err_q | abort;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                if (dm_elig) begin
                    bus_d   = '{req:      1'b1,
                                addr:     i_dm_addr,
                                wr_en:    i_dm_wr_en,
                                wr_data:  i_dm_wr_data,
                                byte_sel: i_dm_byte_sel};
                    state_d = ARB_BUSY_DM;
                end else if (if_elig) begin
                    bus_d   = '{req:      1'b1,
                                addr:     i_if_addr,
                                wr_en:    1'b0,
                                wr_data:  '0,
                                byte_sel: IF_BYTE_SEL};
                    state_d = ARB_BUSY_IF;
                end
            end
            ARB_BUSY_IF: begin
                if (bus_ack || abort) begin
                    bus_d.req = 1'b0;
                    if_ack_d  = 1'b1;
                    if_rd_d   = bus_ack ? i_bus_rd_data : '0;
                    state_d   = ARB_IDLE;
                end
            end
            ARB_BUSY_DM: begin
                if (bus_ack || abort) begin
                    bus_d.req = 1'b0;
                    dm_ack_d  = 1'b1;
                    if (!bus_ack) begin
                        dm_rd_d = '0;
                    end else if (!bus_q.wr_en) begin
                        dm_rd_d = i_bus_rd_data;
                    end
                    state_d   = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State, bus and response registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ARB_IDLE;
            bus_q    <= '0;
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            if_rd_q  <= '0;
            dm_rd_q  <= '0;
`ifdef RISCV_ARB_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            bus_q    <= bus_d;
            if_ack_q <= if_ack_d;
            dm_ack_q <= dm_ack_d;
            if_rd_q  <= if_rd_d;
            dm_rd_q  <= dm_rd_d;
`ifdef RISCV_ARB_TIMEOUT_EN
            err_q    <= err_d;
`endif
        end
    end

    assign o_if_ack       = if_ack_q;
    assign o_if_rd_data   = if_rd_q;
    assign o_dm_ack       = dm_ack_q;
    assign o_dm_rd_data   = dm_rd_q;
    assign o_arb_stall_f  = i_if_req & ~if_ack_q;
    assign o_arb_stall_m  = i_dm_req & ~dm_ack_q;
    assign o_bus_req      = bus_q.req;
    assign o_bus_addr     = bus_q.addr;
    assign o_bus_wr_en    = bus_q.wr_en;
    assign o_bus_wr_data  = bus_q.wr_data;
    assign o_bus_byte_sel = bus_q.byte_sel;

endmodule
